// File: rtl/mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq
//  Purpose  : Multi-cycle sequential multiplier, WIDTH x WIDTH -> 2*WIDTH.
//             Multiplies the operand magnitudes CHUNK bits of `a` per cycle,
//             then applies the sign of the product. Signed or unsigned mode
//             is selected per operation.
//  Ports    : clk          - clock; all logic on the rising edge
//             reset        - synchronous, active-high reset
//             start        - operation request; accepted only when idle
//             signed_mode  - 1: two's complement operands/result; 0: unsigned
//             a, b         - WIDTH-bit operands, sampled with start
//             busy         - high while an operation is in flight
//             done         - one-cycle pulse when product is updated
//             product      - last completed 2*WIDTH-bit result
//  Revision : 1.0  initial release
// ============================================================================
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  // Reject operand/slice width combinations that do not divide evenly.
  generate
    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
      $error("mult_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_FINAL = 2'd2
  } state_t;

  state_t               r_state;
  logic [KW-1:0]        r_k;
  logic [WIDTH-1:0]     r_amag;   // remaining slices of |a|, consumed LSB first
  logic [2*WIDTH-1:0]   r_bsh;    // |b| pre-shifted to the current slice weight
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;

  logic [WIDTH-1:0]     w_amag;
  logic [WIDTH-1:0]     w_bmag;
  logic [2*WIDTH-1:0]   w_term;

  // In signed mode the negation of the most negative value wraps to
  // 2^(WIDTH-1), which is exactly the correct unsigned magnitude.
  assign w_amag = (signed_mode && a[WIDTH-1]) ? (-a) : a;
  assign w_bmag = (signed_mode && b[WIDTH-1]) ? (-b) : b;

  // Shifting the operands each step replaces a variable-index slice and a
  // variable left shift; the term equals slice_k(|a|) * |b| << (k*CHUNK).
  assign w_term = {{(2*WIDTH-CHUNK){1'b0}}, r_amag[CHUNK-1:0]} * r_bsh;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_amag  <= '0;
      r_bsh   <= '0;
      r_acc   <= '0;
      r_neg   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_amag  <= w_amag;
            r_bsh   <= {{WIDTH{1'b0}}, w_bmag};
            r_neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_acc   <= '0;
            r_k     <= '0;
            busy    <= 1'b1;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc  <= r_acc + w_term;
          r_amag <= r_amag >> CHUNK;
          r_bsh  <= r_bsh << CHUNK;
          r_k    <= r_k + 1'b1;
          if (r_k == KW'(N - 1)) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          product <= r_neg ? (-r_acc) : r_acc;
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_seq
//  Purpose  : Self-checking bench for mult_seq. A 32x32/8 instance covers the
//             reset, signed/unsigned, ignored-start and abort scenarios; a
//             16x16/4 instance covers the narrow width and back-to-back mode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mult_seq;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, signed_mode;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  logic        start2, sm2;
  logic [15:0] a2, b2;
  logic        busy2, done2;
  logic [31:0] product2;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] q[$];

  mult_seq dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  mult_seq #(.WIDTH(16), .CHUNK(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .signed_mode(sm2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
  );

  function automatic logic [63:0] model(input logic sm, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy;
    if (sm) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL reset_state busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    checks++;
    if (busy2 !== 1'b0 || done2 !== 1'b0 || product2 !== 32'd0) begin
      errors++;
      $display("FAIL reset_state_w16 busy=%b done=%b product=%h required 0 0 0", busy2, done2, product2);
    end
  endtask

  // Runs one operation on the 32-bit instance. inject_at >= 0 raises start
  // with other operands during that busy cycle (must be ignored).
  task automatic do_op(input string name, input logic sm, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [63:0] spec_val, input int inject_at);
    int          bcyc, dcnt;
    bit          got, midbad;
    logic [63:0] prev, expv, got_p;
    @(negedge clk);
    signed_mode = sm; a = aa; b = bb; start = 1'b1;
    q.push_back(model(sm, aa, bb));
    prev = product;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; signed_mode = ~sm;
    bcyc = 0; dcnt = 0; got = 0; midbad = 0; got_p = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (i == inject_at) begin start = 1'b1; a = 32'd9; b = 32'd9; end
      if (i == inject_at + 1) start = 1'b0;
      if (busy) begin
        bcyc++;
        if (product !== prev || done !== 1'b0) midbad = 1;
      end
      if (done) begin dcnt++; got = 1; got_p = product; end
      if (!got) @(negedge clk);
    end
    start = 1'b0;
    expv = q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s_timeout done=0 required done pulse within 20 cycles", name);
    end
    checks++;
    if (got_p !== expv || got_p !== spec_val) begin
      errors++;
      $display("FAIL %s_product got=%h required=%h (model %h)", name, got_p, spec_val, expv);
    end
    checks++;
    if (bcyc != 5) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d required=5", name, bcyc);
    end
    checks++;
    if (midbad) begin
      errors++;
      $display("FAIL %s_intermediate product or done changed while busy (prev=%h)", name, prev);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== expv) begin
      errors++;
      $display("FAIL %s_after done=%b busy=%b product=%h required 0 0 %h", name, done, busy, product, expv);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    @(negedge clk);
    signed_mode = 1'b0; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++;
      $display("FAIL abort_state busy=%b done=%b product=%h required 0 0 0", busy, done, product);
    end
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done !== 1'b0 || busy !== 1'b0) saw_done = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_quiet activity after abort, required busy=0 done=0");
    end
    do_op("after_abort", 1'b0, 32'd5, 32'd5, 64'd25, -1);
  endtask

  task automatic test_w16();
    int bcyc;
    bit got;
    @(negedge clk);
    sm2 = 1'b0; a2 = 16'hFFFF; b2 = 16'hFFFF; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bcyc = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy2) bcyc++;
      if (done2) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got || product2 !== 32'hFFFE0001) begin
      errors++;
      $display("FAIL w16_product done=%b product=%h required=fffe0001", got, product2);
    end
    checks++;
    if (bcyc != 5) begin
      errors++;
      $display("FAIL w16_busy_cycles got=%0d required=5", bcyc);
    end
  endtask

  task automatic test_back_to_back();
    int          last, pulses;
    logic [31:0] expv;
    @(negedge clk);
    sm2 = 1'b0; a2 = 16'h1234; b2 = 16'h00FF; start2 = 1'b1;
    expv = 32'h0000_1234 * 32'h0000_00FF;
    last = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done2) begin
        pulses++;
        checks++;
        if (product2 !== expv) begin
          errors++;
          $display("FAIL b2b_product got=%h required=%h", product2, expv);
        end
        if (last >= 0) begin
          checks++;
          if (i - last != 6) begin
            errors++;
            $display("FAIL b2b_interval got=%0d required=6", i - last);
          end
        end
        last = i;
      end
    end
    start2 = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (pulses < 5 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pulses got=%0d busy=%b required>=5 busy=0", pulses, busy2);
    end
  endtask

  initial begin
    test_reset();
    do_op("unsigned_basic", 1'b0, 32'd316007988, 32'd208397414, 64'd65855247502543032, -1);
    do_op("unsigned_max",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, -1);
    do_op("signed_m1_m1",   1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001, -1);
    do_op("signed_m3_5",    1'b1, 32'hFFFFFFFD, 32'd5,        64'hFFFFFFFFFFFFFFF1, -1);
    do_op("signed_minmin",  1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000, -1);
    do_op("ignored_start",  1'b0, 32'd7,        32'd6,        64'd42,               1);
    test_abort();
    test_w16();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised multi-cycle sequential multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Successor to the fixed 32x32 start/busy multiplier. Adds configurable operand width, a configurable per-cycle slice width, a signed/unsigned mode, and a one-cycle done pulse.
- Sits on the datapath as a shared arithmetic unit and uses the same start/busy handshake as the existing multiplier.

Parameters:
- WIDTH, 32, operand width in bits; result is 2*WIDTH.
- CHUNK, 8, bits of operand a consumed per iteration. WIDTH % CHUNK must be 0, otherwise elaboration error.
- N (localparam), WIDTH/CHUNK, number of accumulate iterations.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy==0.
- signed_mode  in  1  1: a, b and product are two's complement; 0: unsigned. Sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse when product is updated.
- product  out  2*WIDTH  last completed result; holds until the next completion.

Behaviour:
- Reset (sync, active-high, overrides everything): state=IDLE, busy=0, done=0, product=0, accumulator=0, step counter=0. Reset mid-operation aborts it; no done pulse; product returns to 0.
- States: IDLE -> CALC -> FINAL -> IDLE.
- IDLE, edge T with start=1:
  - latch |a|, |b| (WIDTH-bit magnitudes) and neg = signed_mode & (a[W-1]^b[W-1]);
  - acc<=0, k<=0, state<=CALC, busy<=1.
- Operand registers: in unsigned mode the magnitude is the raw operand. In signed mode, -2^(W-1) has magnitude 2^(W-1), which fits in W unsigned bits.
- CALC, edges T+1..T+N: acc <= acc + ((amag[k*CHUNK +: CHUNK] * bmag) << (k*CHUNK)); k<=k+1. After step k=N-1, state<=FINAL.
- Accumulator is 2*WIDTH bits; no overflow is possible.
- FINAL, edge T+N+1: product <= neg ? -acc : acc (2*WIDTH two's complement); done<=1 for exactly one cycle; busy<=0; state<=IDLE.
- Latency: busy high for N+1 cycles; product and done valid after edge T+N+1. With defaults, N=4, so busy lasts 5 cycles.
- start while busy==1 is ignored; operands are not re-sampled. Earliest next accept is the edge after done (T+N+2).
- start held high continuously gives back-to-back operations every N+2 cycles.
- Input changes during busy have no effect on the result.
- product is not modified during CALC; intermediate values are never visible.
- done is 0 in every cycle except the FINAL-completion cycle.

Test Plan:
- Reset held 4 cycles, then release -> busy=0, done=0, product=0. Unsigned a=316007988, b=208397414, start for 1 cycle -> busy high 5 cycles, done pulses once, product=65855247502543032.
- Unsigned a=b=0xFFFFFFFF -> product=0xFFFFFFFE00000001. Signed a=b=0xFFFFFFFF (-1*-1) -> product=0x0000000000000001.
- Signed a=-3 (0xFFFFFFFD), b=5 -> product=0xFFFFFFFFFFFFFFF1. Signed a=b=0x80000000 -> product=0x4000000000000000.
- start pulsed with a=7, b=6; at cycle 2 of busy, start=1 with a=9, b=9 -> ignored; product=42 and a single done pulse.
- Operation in flight with a=5, b=5; reset asserted at CALC step 2 -> next cycle busy=0, no done pulse, product=0. A new start afterwards completes normally.
- Instance WIDTH=16, CHUNK=4, unsigned 0xFFFF*0xFFFF -> busy 5 cycles, product=0xFFFE0001. Same instance with start held high -> a done pulse every 6 cycles.
